arty_clkgen_multi: RTL and testbench

//  Parametrised behavioural clock generator: the simulation stand-in for a multi-output MMCM.

---
 rtl/arty_clkgen_multi_if.sv | 28 ++
 rtl/arty_clkgen_multi.sv | 127 ++++++++++++
 tb/tb_arty_clkgen_multi.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/arty_clkgen_multi_if.sv
// Reprogramming port of the behavioural clock generator.
// The master requests a new divide ratio for one channel. The slave (the generator)
// reports readiness and flags requests that name a channel it does not have.
interface arty_clkgen_multi_if #(
  parameter int DW = 8
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_ch;
  logic [DW-1:0] cfg_div;
  logic          cfg_err;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/arty_clkgen_multi.sv
// Behavioural multi-output clock generator, standing in for an MMCM in simulation.
// Each channel divides clk_in by its own integer ratio. After reset or any accepted
// reprogram request, the outputs are held low for a lock delay. All channels then
// restart together, phase-aligned.
module arty_clkgen_multi #(
  parameter int                  NCH         = 3,
  parameter int                  DW          = 8,
  parameter logic [NCH*DW-1:0]   DIV_INIT    = {8'd8, 8'd4, 8'd2},
  parameter int                  LOCK_CYCLES = 16
) (
  input  logic             clk_in,
  input  logic             resetn,
  output logic [NCH-1:0]   clk_out,
  output logic             locked,
  arty_clkgen_multi_if.slave cfg
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t                  state_r;
  logic [LW-1:0]           lock_cnt_r;
  logic [NCH-1:0][DW-1:0]  div_r;
  logic [NCH-1:0][DW-1:0]  cnt_r;
  logic [NCH-1:0]          clk_out_r;
  logic                    locked_r;
  logic                    err_r;

  logic [NCH-1:0][DW-1:0]  cnt_nxt_s;
  logic [NCH-1:0][DW:0]    half_s;
  logic [NCH-1:0]          clk_nxt_s;
  logic                    accept_s;
  logic                    ch_ok_s;

  // Ratios below 2 cannot produce a toggling clock, so they are raised to 2.
  function automatic logic [DW-1:0] clamp_div(input logic [DW-1:0] d);
    clamp_div = (d < DW'(2)) ? DW'(2) : d;
  endfunction

  assign accept_s = cfg.cfg_valid && locked_r;
  assign ch_ok_s  = ({29'd0, cfg.cfg_ch} < 32'(NCH));

  // Next counter value and next output level per channel while running.
  always_comb begin
    cnt_nxt_s = '0;
    half_s    = '0;
    clk_nxt_s = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cnt_r[i] == div_r[i] - DW'(1)) begin
        cnt_nxt_s[i] = '0;
      end else begin
        cnt_nxt_s[i] = cnt_r[i] + DW'(1);
      end
      half_s[i]    = ({1'b0, div_r[i]} + (DW+1)'(1)) >> 1;
      clk_nxt_s[i] = ({1'b0, cnt_nxt_s[i]} < half_s[i]);
    end
  end

  // Lock sequencing, divider programming and registered clock outputs.
  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      state_r    <= LOCKING;
      lock_cnt_r <= '0;
      clk_out_r  <= '0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      cnt_r      <= '0;
      for (int i = 0; i < NCH; i++) begin
        div_r[i] <= clamp_div(DIV_INIT[i*DW +: DW]);
      end
    end else begin
      err_r <= 1'b0;
      case (state_r)
        LOCKING: begin
          if (lock_cnt_r == LW'(LOCK_CYCLES - 1)) begin
            state_r    <= LOCKED;
            lock_cnt_r <= '0;
            locked_r   <= 1'b1;
            cnt_r      <= '0;
            clk_out_r  <= '1;
          end else begin
            lock_cnt_r <= lock_cnt_r + LW'(1);
            clk_out_r  <= '0;
          end
        end
        LOCKED: begin
          if (accept_s && ch_ok_s) begin
            for (int i = 0; i < NCH; i++) begin
              if (cfg.cfg_ch == 3'(i)) begin
                div_r[i] <= clamp_div(cfg.cfg_div);
              end else begin
                div_r[i] <= div_r[i];
              end
            end
            state_r    <= LOCKING;
            lock_cnt_r <= '0;
            locked_r   <= 1'b0;
            clk_out_r  <= '0;
            cnt_r      <= '0;
          end else begin
            // A request naming a missing channel leaves the clocks running untouched.
            err_r     <= accept_s;
            cnt_r     <= cnt_nxt_s;
            clk_out_r <= clk_nxt_s;
          end
        end
        default: begin
          state_r    <= LOCKING;
          lock_cnt_r <= '0;
          locked_r   <= 1'b0;
          clk_out_r  <= '0;
          cnt_r      <= '0;
        end
      endcase
    end
  end

  assign clk_out       = clk_out_r;
  assign locked        = locked_r;
  assign cfg.cfg_ready = locked_r;
  assign cfg.cfg_err   = err_r;

endmodule

// File: tb/tb_arty_clkgen_multi.sv
// Self-checking bench for arty_clkgen_multi.
// Expected per-edge outputs are derived from each channel's ratio and the number of
// edges since the last lock. They are queued when stimulus is planned, then popped
// and compared one per clk_in edge.
module tb_arty_clkgen_multi;
  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int LC  = 16;

  logic           clk_in = 1'b0;
  logic           resetn;
  logic [NCH-1:0] clk_out;
  logic           locked;

  arty_clkgen_multi_if #(.DW(DW)) cfg ();

  arty_clkgen_multi #(
    .NCH(NCH), .DW(DW), .DIV_INIT({8'd8, 8'd4, 8'd2}), .LOCK_CYCLES(LC)
  ) dut (
    .clk_in (clk_in),
    .resetn (resetn),
    .clk_out(clk_out),
    .locked (locked),
    .cfg    (cfg)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0] co;
    logic       lk;
    logic       er;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   m_div[3];
  int   phase;

  // Level of every channel k edges after the lock edge (the lock edge is k=0).
  function automatic logic [2:0] exp_at(input int k);
    logic [2:0] v;
    v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      v[i] = ((k % m_div[i]) < ((m_div[i] + 1) / 2));
    end
    return v;
  endfunction

  task automatic push_item(input logic [2:0] co, input logic lk, input logic er);
    exp_t e;
    e.co = co; e.lk = lk; e.er = er;
    sbq.push_back(e);
  endtask

  task automatic push_locking();
    repeat (LC - 1) push_item(3'b000, 1'b0, 1'b0);
    phase = 0;
    push_item(exp_at(0), 1'b1, 1'b0);
  endtask

  task automatic push_run(input int n, input logic first_err);
    for (int j = 0; j < n; j++) begin
      phase++;
      push_item(exp_at(phase), 1'b1, (j == 0) ? first_err : 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    resetn = 1'b0;
    m_div[0] = 2; m_div[1] = 4; m_div[2] = 8;
    tick(); tick();
    total++;
    if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== 6'b000_000) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, 6'b0);
    end
    #1 resetn = 1'b1;
    push_locking();
    push_run(16, 1'b0);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL reset_lock cyc=%0d got=%b exp=%b", cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
    end
  endtask

  task automatic test_reprogram();
    exp_t e;
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd1; cfg.cfg_div = 8'd5;
    push_item(3'b000, 1'b0, 1'b0);
    m_div[1] = 5;
    push_locking();
    push_run(20, 1'b0);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL reprogram cyc=%0d got=%b exp=%b", cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
      if (cyc == 0) cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_div_clamp(input logic [7:0] d);
    exp_t e;
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd0; cfg.cfg_div = d;
    push_item(3'b000, 1'b0, 1'b0);
    m_div[0] = 2;
    push_locking();
    push_run(8, 1'b0);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL div_clamp d=%0d cyc=%0d got=%b exp=%b", d, cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
      if (cyc == 0) cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_bad_channel();
    exp_t e;
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd5; cfg.cfg_div = 8'd3;
    push_run(12, 1'b1);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL bad_channel cyc=%0d got=%b exp=%b", cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
      if (cyc == 0) cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_hold_valid();
    exp_t e;
    // Rewriting ch2 with its current ratio still relocks.
    cfg.cfg_valid = 1'b1; cfg.cfg_ch = 3'd2; cfg.cfg_div = 8'd8;
    push_item(3'b000, 1'b0, 1'b0);
    m_div[2] = 8;
    push_locking();
    push_item(3'b000, 1'b0, 1'b0);
    m_div[0] = 3;
    push_locking();
    push_run(12, 1'b0);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL hold_valid cyc=%0d got=%b exp=%b", cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
      if (cyc == 0) begin
        cfg.cfg_ch = 3'd0; cfg.cfg_div = 8'd3;
      end
      if (cyc == LC + 1) cfg.cfg_valid = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    tick();
    #2 resetn = 1'b0;
    #1;
    total++;
    if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== 6'b000_000) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, 6'b0);
    end
    #1 resetn = 1'b1;
    m_div[0] = 2; m_div[1] = 4; m_div[2] = 8;
    push_locking();
    push_run(16, 1'b0);
    for (int cyc = 0; sbq.size() > 0; cyc++) begin
      tick();
      e = sbq.pop_front();
      total++;
      if ({clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !== {e.co, e.lk, e.lk, e.er}) begin
        bad++;
        $display("FAIL async_relock cyc=%0d got=%b exp=%b", cyc,
                 {clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, {e.co, e.lk, e.lk, e.er});
      end
    end
  endtask

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = 3'd0;
    cfg.cfg_div   = 8'd0;
    phase         = 0;
    test_reset();
    test_reprogram();
    test_div_clamp(8'd0);
    test_div_clamp(8'd1);
    test_bad_channel();
    test_hold_valid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
